// File: rtl/matrix_frame_loader_if.sv
// Sequencer-side bus of matrix_frame_loader: host control, frame memory read port and matrix driver strobes.
// Optional MATRIX_LOADER_SCROLL_EN adds the scroll_offset input.
interface matrix_frame_loader_if #(
    parameter int unsigned NUM_COLS = 32,
    parameter int unsigned COL_W    = 16
);
    localparam int unsigned IDX_W = $clog2(NUM_COLS);

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             mem_rd;
    logic [IDX_W-1:0] mem_addr;
    logic [COL_W-1:0] mem_data;
    logic [COL_W-1:0] in_column;
    logic             LOAD;
    logic             IN_CLR;
    logic [IDX_W-1:0] column_id;
`ifdef MATRIX_LOADER_SCROLL_EN
    logic [IDX_W-1:0] scroll_offset;
`endif

    modport master (
        input  start, abort, mem_data,
`ifdef MATRIX_LOADER_SCROLL_EN
        input  scroll_offset,
`endif
        output busy, done, mem_rd, mem_addr, in_column, LOAD, IN_CLR, column_id
    );

    modport slave (
        output start, abort, mem_data,
`ifdef MATRIX_LOADER_SCROLL_EN
        output scroll_offset,
`endif
        input  busy, done, mem_rd, mem_addr, in_column, LOAD, IN_CLR, column_id
    );
endinterface

// File: rtl/matrix_frame_loader.sv
// Uploads one frame from a synchronous frame memory into the dot-matrix column driver.
// Define MATRIX_LOADER_SCROLL_EN to rotate memory addresses by a per-frame scroll offset.
module matrix_frame_loader #(
    parameter int unsigned NUM_COLS     = 32,
    parameter int unsigned COL_W        = 16,
    parameter int unsigned CLR_CYCLES   = 2,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    matrix_frame_loader_if.master bus
);
    localparam int unsigned IDX_W     = $clog2(NUM_COLS);
    localparam int unsigned SUM_W     = IDX_W + 1;
    localparam int unsigned MAX_A     = (CLR_CYCLES > SETUP_CYCLES) ? CLR_CYCLES : SETUP_CYCLES;
    localparam int unsigned MAX_B     = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_DWELL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned DWELL_W   = $clog2(MAX_DWELL + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_SETUP, S_PULSE, S_HOLD, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   col_q, col_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]   offset_q, offset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mem_rd_q, mem_rd_d;
    logic [IDX_W-1:0]   mem_addr_q, mem_addr_d;
    logic [COL_W-1:0]   in_column_q, in_column_d;
    logic               load_q, load_d;
    logic               in_clr_q, in_clr_d;
    logic [IDX_W-1:0]   column_id_q, column_id_d;
    logic [IDX_W-1:0]   fetch_addr;
    logic [SUM_W-1:0]   addr_sum;

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            dwell_q     <= '0;
            offset_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            in_column_q <= '0;
            load_q      <= 1'b0;
            in_clr_q    <= 1'b0;
            column_id_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            offset_q    <= offset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            in_column_q <= in_column_d;
            load_q      <= load_d;
            in_clr_q    <= in_clr_d;
            column_id_q <= column_id_d;
        end
    end

    // Next state, column counter and per-state dwell counter
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            col_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d = S_CLEAR;
                        col_d   = '0;
                    end
                end
                S_CLEAR: if (dwell_q == DWELL_W'(CLR_CYCLES - 1)) state_d = S_FETCH;
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  state_d = S_SETUP;
                S_SETUP: if (dwell_q == DWELL_W'(SETUP_CYCLES - 1)) state_d = S_PULSE;
                S_PULSE: if (dwell_q == DWELL_W'(PULSE_CYCLES - 1)) state_d = S_HOLD;
                S_HOLD: begin
                    if (dwell_q == DWELL_W'(HOLD_CYCLES - 1)) begin
                        if (col_q == IDX_W'(NUM_COLS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH;
                            col_d   = col_q + IDX_W'(1);
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        dwell_d = (state_d != state_q || state_d == S_IDLE) ? '0 : dwell_q + DWELL_W'(1);
    end

    // Output values as they will be after the coming edge
    always_comb begin
        offset_d = offset_q;
        addr_sum = '0;
`ifdef MATRIX_LOADER_SCROLL_EN
        if (state_q == S_IDLE && state_d == S_CLEAR) offset_d = bus.scroll_offset;
        addr_sum = SUM_W'(col_d) + SUM_W'(offset_q);
        if (addr_sum >= SUM_W'(NUM_COLS)) addr_sum = addr_sum - SUM_W'(NUM_COLS);
        fetch_addr = addr_sum[IDX_W-1:0];
`else
        fetch_addr = col_d;
`endif
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        mem_rd_d    = (state_d == S_FETCH);
        load_d      = (state_d == S_PULSE);
        in_clr_d    = (state_d == S_CLEAR);
        mem_addr_d  = (state_d == S_FETCH) ? fetch_addr : mem_addr_q;
        in_column_d = in_column_q;
        column_id_d = column_id_q;
        if (state_q == S_WAIT && state_d == S_SETUP) begin
            in_column_d = bus.mem_data;
            column_id_d = col_q;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.in_column = in_column_q;
    assign bus.LOAD      = load_q;
    assign bus.IN_CLR    = in_clr_q;
    assign bus.column_id = column_id_q;
endmodule

// File: tb/tb_matrix_frame_loader.sv
// Directed bench for matrix_frame_loader: full frames, start held, abort, start+abort, async reset, scroll.
module tb_matrix_frame_loader;
    logic CLK;
    logic RESET;
    int   total = 0;
    int   bad   = 0;

    matrix_frame_loader_if #(.NUM_COLS(32), .COL_W(16)) bus_if ();

    matrix_frame_loader #(
        .NUM_COLS(32), .COL_W(16), .CLR_CYCLES(2),
        .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous frame memory: word k = 16'hA000 + k, one cycle latency
    always @(posedge CLK) begin
        if (bus_if.mem_rd) bus_if.mem_data <= 16'hA000 + 16'(bus_if.mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] ctrl_now();
        return {bus_if.busy, bus_if.done, bus_if.mem_rd, bus_if.LOAD, bus_if.IN_CLR};
    endfunction

    function automatic logic [30:0] all_out();
        return {ctrl_now(), bus_if.mem_addr, bus_if.column_id, bus_if.in_column};
    endfunction

    // Expected {busy,done,mem_rd,LOAD,IN_CLR} after edge N+e, start sampled at edge N
    function automatic logic [4:0] exp_ctrl(input int e);
        logic b, d, rd, ld, clr;
        int   ph;
        b   = (e <= 194);
        d   = (e == 194);
        clr = (e <= 1);
        rd  = 1'b0;
        ld  = 1'b0;
        if (e >= 2 && e <= 193) begin
            ph = (e - 2) % 6;
            rd = (ph == 0);
            ld = (ph == 3) || (ph == 4);
        end
        return {b, d, rd, ld, clr};
    endfunction

    task automatic frame_check(input bit drop_start, input int last_e, input int off);
        int k, ph;
        logic [15:0] addr;
        for (int e = 0; e <= last_e; e++) begin
            step();
            if (e == 0 && drop_start) bus_if.start = 1'b0;
`ifdef MATRIX_LOADER_SCROLL_EN
            if (e == 0) bus_if.scroll_offset = 5'(off + 7);
`endif
            chk($sformatf("ctrl e=%0d", e), 64'(ctrl_now()), 64'(exp_ctrl(e)));
            if (e >= 2 && e <= 193) begin
                k    = (e - 2) / 6;
                ph   = (e - 2) % 6;
                addr = 16'((k + off) % 32);
                if (ph == 0) chk($sformatf("mem_addr col=%0d", k), 64'(bus_if.mem_addr), 64'(addr));
                if (ph == 5) begin
                    chk($sformatf("in_column col=%0d", k), 64'(bus_if.in_column), 64'(16'hA000 + addr));
                    chk($sformatf("column_id col=%0d", k), 64'(bus_if.column_id), 64'(k));
                end
            end
            if (e == 195) chk("column_id kept", 64'(bus_if.column_id), 64'(31));
        end
    endtask

    initial begin
        int rd_seen;
        RESET          = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.abort   = 1'b0;
`ifdef MATRIX_LOADER_SCROLL_EN
        bus_if.scroll_offset = 5'd0;
`endif
        repeat (2) step();
        chk("reset outputs", 64'(all_out()), 64'(0));
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) step();
        chk("idle busy", 64'(bus_if.busy), 64'(0));

        // Single start pulse, full frame
        bus_if.start = 1'b1;
        frame_check(1'b1, 195, 0);

        // start held: in-frame start ignored, second frame right after DONE->IDLE
        bus_if.start = 1'b1;
        frame_check(1'b0, 195, 0);
        frame_check(1'b0, 195, 0);
        bus_if.start = 1'b0;
        step();
        chk("idle after held start", 64'(ctrl_now()), 64'(0));

        // Abort during PULSE of column 7
        bus_if.start = 1'b1;
        frame_check(1'b1, 47, 0);
        chk("load before abort", 64'(bus_if.LOAD), 64'(1));
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        chk("abort ctrl", 64'(ctrl_now()), 64'(0));
        rd_seen = 0;
        repeat (20) begin
            step();
            if (bus_if.mem_rd || bus_if.busy || bus_if.done) rd_seen++;
        end
        chk("quiet after abort", 64'(rd_seen), 64'(0));
        bus_if.start = 1'b1;
        frame_check(1'b1, 195, 0);

        // start and abort together in IDLE
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("start+abort idle %0d", i), 64'(ctrl_now()), 64'(0));
        end
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;

        // Asynchronous reset mid-frame at column 20
        bus_if.start = 1'b1;
        frame_check(1'b1, 125, 0);
        chk("column 20 presented", 64'(bus_if.column_id), 64'(20));
        #3;
        RESET = 1'b0;
        #1;
        chk("async reset outputs", 64'(all_out()), 64'(0));
        @(negedge CLK);
        RESET = 1'b1;
        rd_seen = 0;
        repeat (5) begin
            step();
            if (ctrl_now() != 5'd0) rd_seen++;
        end
        chk("idle after reset", 64'(rd_seen), 64'(0));
        bus_if.start = 1'b1;
        frame_check(1'b1, 195, 0);

`ifdef MATRIX_LOADER_SCROLL_EN
        // Scroll offset 30, changed mid-frame without effect
        bus_if.scroll_offset = 5'd30;
        bus_if.start = 1'b1;
        frame_check(1'b1, 195, 30);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_frame_loader.md
Name: matrix_frame_loader

Overview:
- Sequencer that uploads one full frame (NUM_COLS columns × COL_W bits) from an external synchronous frame memory into the dot-matrix column driver.
- Generates the in_column data, LOAD strobes, the IN_CLR pre-clear and the column index that the matrix driver consumes.
- Sits between the frame memory / host logic and the matrix driver, replacing free-running LOAD-edge column counting with a clocked, abortable, single-clock sequencer.

Parameters:
- NUM_COLS, 32, columns per frame; index width is clog2(NUM_COLS), 5 at default.
- COL_W, 16, bits per column.
- CLR_CYCLES, 2, cycles IN_CLR is held high at frame start (≥1).
- SETUP_CYCLES, 1, cycles in_column is stable with LOAD low before LOAD rises (≥1).
- PULSE_CYCLES, 2, cycles LOAD is held high (≥1).
- HOLD_CYCLES, 1, cycles in_column is held after LOAD falls (≥1).

Ports:
- CLK, input, 1, single system clock; all logic on rising edge.
- RESET, input, 1, asynchronous, active-low reset.
- start, input, 1, request a frame upload; sampled only in IDLE.
- abort, input, 1, terminate the upload in progress.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when the last column has completed HOLD.
- mem_rd, output, 1, one-cycle read strobe to the frame memory.
- mem_addr, output, 5, column address presented with mem_rd.
- mem_data, input, COL_W, read data, valid exactly 1 cycle after mem_rd.
- in_column, output, COL_W, column data to the matrix driver.
- LOAD, output, 1, column load strobe; the driver latches on the falling edge.
- IN_CLR, output, 1, clear strobe to the driver's input stage.
- column_id, output, 5, index of the column currently presented.

Behaviour:
- Reset (RESET low, asynchronous): state IDLE; busy, done, mem_rd, LOAD, IN_CLR = 0; mem_addr, column_id = 0; in_column = 0.
- All outputs are registered.
- IDLE: start=1 and abort=0 → CLEAR, with column counter = 0. If start and abort are both 1, abort wins and the block stays in IDLE.
- CLEAR: IN_CLR=1 for CLR_CYCLES cycles → FETCH.
- FETCH (1 cycle): mem_rd=1, mem_addr = memory address of the current column → WAIT.
- WAIT (1 cycle): at the exit edge, in_column latches mem_data and column_id = column counter → SETUP.
- SETUP: LOAD=0 for SETUP_CYCLES → PULSE.
- PULSE: LOAD=1 for PULSE_CYCLES → HOLD.
- HOLD: LOAD=0 and in_column unchanged for HOLD_CYCLES.
  - If counter = NUM_COLS-1 → DONE.
  - Otherwise the counter increments and the FSM returns to FETCH.
- DONE (1 cycle): done=1 → IDLE. column_id and in_column keep their last values.
- start while busy is ignored; it is not queued.
- abort, in any non-IDLE state: next edge forces IDLE.
  - LOAD, IN_CLR and mem_rd go low on that edge.
  - The counter resets to 0; done is not asserted.
  - A LOAD already high therefore falls, and the driver latches that column. This is accepted.
- Counter wrap: it never exceeds NUM_COLS-1; no increment past the last column.
- Frame timing at defaults, start sampled at edge N:
  - Per column: FETCH 1 + WAIT 1 + SETUP 1 + PULSE 2 + HOLD 1 = 6 cycles.
  - CLEAR occupies edges N..N+1; columns occupy edges N+2..N+193.
  - done is high in the cycle after edge N+194; busy falls at edge N+195.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro: MATRIX_LOADER_SCROLL_EN.
- Defined: adds input scroll_offset (5 bits), sampled into a shadow register at the IDLE→CLEAR transition only.
  - mem_addr = (counter + offset) mod NUM_COLS, 5-bit wrap.
  - column_id still equals the counter, i.e. physical column position.
  - Changing scroll_offset mid-frame has no effect until the next start.
- Undefined: port absent; mem_addr = counter.

Test Plan:
- Reset then start pulse; memory word k = 16'hA000+k → IN_CLR high 2 cycles, then 32 LOAD pulses of 2 cycles each. At each LOAD fall, in_column = 16'hA000+column_id and column_id = 0..31 in order. done pulses once in the cycle after edge N+194.
- start held high for 400 cycles → first frame behaves as above. In-frame start is ignored; a second frame begins on the edge after DONE returns to IDLE.
- abort asserted during the PULSE of column 7 → LOAD low next edge, busy low next edge, no done, mem_rd never again. A fresh start restarts at column_id 0 with IN_CLR.
- start and abort together in IDLE → stays IDLE, busy=0, no IN_CLR.
- RESET driven low mid-frame at column 20 asynchronously (between edges) → all outputs 0 immediately. After RESET high, block is idle until the next start.
- With MATRIX_LOADER_SCROLL_EN and scroll_offset=30: column_id 0 reads mem_addr 30, column_id 1 reads 31, column_id 2 reads 0 (wrap), column_id 31 reads 29. Changing the offset mid-frame has no effect.
